// File: rtl/pcihellocore_pio_pkg.sv
// Shared definitions for the switch/key parallel input port:
// register map, edge capture modes and the per-bit edge rule.
package pcihellocore_pio_pkg;

  typedef enum logic [1:0] {
    RISING  = 2'd0,
    FALLING = 2'd1,
    ANY     = 2'd2
  } edge_type_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  function automatic logic edge_hit(edge_type_e mode, logic cur, logic prev);
    logic hit;
    hit = 1'b0;
    case (mode)
      RISING:  hit = cur & ~prev;
      FALLING: hit = ~cur & prev;
      ANY:     hit = cur ^ prev;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pcihellocore_sync_edge.sv
// One input bit: multi-flop synchronizer, a delayed copy of the synchronized
// value, and a registered one-cycle pulse when the selected edge is seen.
module pcihellocore_sync_edge
  import pcihellocore_pio_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter edge_type_e EDGE_TYPE   = RISING
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delayed_q;

  // The delayed copy resets to the synchronizer's reset value so that
  // no spurious edge appears right after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      delayed_q  <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
      delayed_q  <= sync_q[SYNC_STAGES-1];
      edge_pulse <= edge_hit(EDGE_TYPE, sync_q[SYNC_STAGES-1], delayed_q);
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pcihellocore_switch_pio.sv
// Avalon-MM parallel input port for switches/keys with per-bit edge capture,
// interrupt mask and a level interrupt.
module pcihellocore_switch_pio
  import pcihellocore_pio_pkg::*;
#(
  parameter int         WIDTH       = 32,
  parameter edge_type_e EDGE_TYPE   = RISING,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_data;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clear_vec;
  logic [31:0]      read_mux;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pcihellocore_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync_edge (
      .clk       (clk),
      .reset     (reset),
      .async_in  (in_port[i]),
      .sync_out  (sync_data[i]),
      .edge_pulse(edge_vec[i])
    );
  end

  assign wr_en     = chipselect & ~write_n;
  assign clear_vec = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  // A fresh edge wins over a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_capture <= (edge_capture & ~clear_vec) | edge_vec;
    end
  end

  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA: read_mux[WIDTH-1:0] = sync_data;
      ADDR_MASK: read_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: read_mux[WIDTH-1:0] = edge_capture;
      default:   read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pcihellocore_switch_pio.sv
// Self-checking bench: three port instances (rising, falling, any-edge) on a
// shared bus, checked every cycle against a latency-based reference model.
module tb_pcihellocore_switch_pio;
  import pcihellocore_pio_pkg::*;

  localparam int S = 2;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_r, in_f, in_a;
  logic [31:0] rd_r, rd_f, rd_a;
  logic        irq_r, irq_f, irq_a;

  int errors;
  int checks;

  // Reference model state: per instance, the input value seen at every clock
  // edge since reset release, plus the expected register contents.
  logic [31:0] hist [3][4096];
  int          cyc;
  logic [31:0] m_cap  [3];
  logic [31:0] m_mask [3];
  logic [31:0] m_rd   [3];

  pcihellocore_switch_pio #(.WIDTH(32), .EDGE_TYPE(RISING), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_r),
    .readdata(rd_r), .irq(irq_r));

  pcihellocore_switch_pio #(.WIDTH(32), .EDGE_TYPE(FALLING), .SYNC_STAGES(S)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_f),
    .readdata(rd_f), .irq(irq_f));

  pcihellocore_switch_pio #(.WIDTH(32), .EDGE_TYPE(ANY), .SYNC_STAGES(S)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] in_of(int m);
    return (m == 0) ? in_r : (m == 1) ? in_f : in_a;
  endfunction

  function automatic logic [31:0] h(int m, int j);
    return (j < 0) ? 32'h0 : hist[m][j];
  endfunction

  function automatic logic [31:0] edges_of(int m, logic [31:0] cur, logic [31:0] prev);
    if (m == 0) return cur & ~prev;
    if (m == 1) return ~cur & prev;
    return cur ^ prev;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic cs, input logic wn, input logic [1:0] a,
                                input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
  endtask

  task automatic check_all(input string tag);
    check_output({tag, "_rd_rise"}, rd_r, m_rd[0]);
    check_output({tag, "_rd_fall"}, rd_f, m_rd[1]);
    check_output({tag, "_rd_any"},  rd_a, m_rd[2]);
    check_output({tag, "_irq_rise"}, {31'b0, irq_r}, {31'b0, |(m_cap[0] & m_mask[0])});
    check_output({tag, "_irq_fall"}, {31'b0, irq_f}, {31'b0, |(m_cap[1] & m_mask[1])});
    check_output({tag, "_irq_any"},  {31'b0, irq_a}, {31'b0, |(m_cap[2] & m_mask[2])});
  endtask

  // One clock edge: the model works purely from latency. An input sampled at
  // edge j is the readable data value S-1 edges later and becomes a capture
  // S+1 edges later.
  task automatic tick();
    logic        wr;
    logic [31:0] clr;
    @(posedge clk);
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata : 32'h0;
    for (int m = 0; m < 3; m++) begin
      case (address)
        2'd0:    m_rd[m] = h(m, cyc - S);
        2'd2:    m_rd[m] = m_mask[m];
        2'd3:    m_rd[m] = m_cap[m];
        default: m_rd[m] = 32'h0;
      endcase
      m_cap[m] = (m_cap[m] & ~clr) | edges_of(m, h(m, cyc - S - 1), h(m, cyc - S - 2));
      if (wr && address == 2'd2) m_mask[m] = writedata;
      hist[m][cyc] = in_of(m);
    end
    cyc++;
    #1;
    check_all("cycle");
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int m = 0; m < 3; m++) begin
      m_cap[m]  = 32'h0;
      m_mask[m] = 32'h0;
      m_rd[m]   = 32'h0;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    in_r = 0; in_f = 0; in_a = 0;
    apply_stimulus(1'b0, 1'b1, 2'd0, 32'h0);
    reset = 1'b1;
    model_reset();
    #3;
    check_all("in_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) tick();

    // Registers all read zero after reset.
    apply_stimulus(1'b1, 1'b1, 2'd0, 32'h0); tick();
    check_output("rst_data", rd_r, 32'h0);
    apply_stimulus(1'b1, 1'b1, 2'd2, 32'h0); tick();
    check_output("rst_mask", rd_r, 32'h0);
    apply_stimulus(1'b1, 1'b1, 2'd3, 32'h0); tick();
    check_output("rst_edge", rd_r, 32'h0);
    check_output("rst_irq", {31'b0, irq_r}, 32'h0);

    // Rising capture latency with mask 0x4.
    apply_stimulus(1'b1, 1'b0, 2'd2, 32'h4); tick();
    apply_stimulus(1'b1, 1'b1, 2'd3, 32'h0);
    in_r = 32'h5;
    repeat (S + 1) tick();
    check_output("irq_before_capture", {31'b0, irq_r}, 32'h0);
    tick();
    check_output("irq_at_capture", {31'b0, irq_r}, 32'h1);
    tick();
    check_output("cap_rise_5", rd_r, 32'h5);
    apply_stimulus(1'b1, 1'b1, 2'd0, 32'h0); tick();
    check_output("data_5", rd_r, 32'h5);

    // Write-1-to-clear drops irq on the same edge.
    apply_stimulus(1'b1, 1'b0, 2'd3, 32'h4); tick();
    check_output("irq_after_clear", {31'b0, irq_r}, 32'h0);
    apply_stimulus(1'b1, 1'b1, 2'd3, 32'h0); tick();
    check_output("cap_after_clear", rd_r, 32'h1);

    // New edge and clear of the same bit on one edge: the set wins.
    apply_stimulus(1'b1, 1'b0, 2'd3, 32'h1); tick();
    apply_stimulus(1'b1, 1'b1, 2'd3, 32'h0);
    in_r = 32'h4;
    repeat (S + 3) tick();
    check_output("cap_cleared", rd_r, 32'h0);
    in_r = 32'h5;
    repeat (S + 1) tick();
    apply_stimulus(1'b1, 1'b0, 2'd3, 32'h1); tick();
    apply_stimulus(1'b1, 1'b1, 2'd3, 32'h0); tick();
    check_output("set_beats_clear", rd_r, 32'h1);

    // Falling and any-edge modes.
    apply_stimulus(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF); tick();
    apply_stimulus(1'b1, 1'b1, 2'd3, 32'h0);
    in_f = 32'hFF;
    repeat (S + 3) tick();
    check_output("fall_ignores_rise", rd_f, 32'h0);
    in_f = 32'h0F;
    repeat (S + 3) tick();
    check_output("fall_f0", rd_f, 32'hF0);
    in_a = 32'h8;
    repeat (S + 3) tick();
    check_output("any_first_toggle", rd_a, 32'h8);
    in_a = 32'h0;
    repeat (S + 3) tick();
    check_output("any_second_toggle", rd_a, 32'h8);

    // Asynchronous reset with captures pending and irq high.
    apply_stimulus(1'b1, 1'b0, 2'd2, 32'hFF); tick();
    apply_stimulus(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
    in_r = 32'h0;
    tick();
    apply_stimulus(1'b1, 1'b1, 2'd3, 32'h0);
    repeat (S + 3) tick();
    in_r = 32'hFF;
    repeat (S + 3) tick();
    check_output("cap_ff", rd_r, 32'hFF);
    check_output("irq_ff", {31'b0, irq_r}, 32'h1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_output("async_rst_rd", rd_r, 32'h0);
    check_output("async_rst_irq", {31'b0, irq_r}, 32'h0);
    check_all("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) tick();
    check_output("no_capture_after_release", rd_r, 32'h0);
    repeat (S + 3) tick();
    check_output("recapture_ff", rd_r, 32'hFF);
    check_output("mask_cleared_irq", {31'b0, irq_r}, 32'h0);

    // Randomized traffic on inputs and bus.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) in_r = in_r ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) in_f = in_f ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) in_a = in_a ^ (32'h1 << $urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0:       apply_stimulus(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom);
        1:       apply_stimulus(1'b1, 1'b0, 2'd3, $urandom & $urandom);
        2:       apply_stimulus(1'b0, 1'b0, 2'd2, $urandom);
        default: apply_stimulus(1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
